// File: rtl/player_motion.sv
// Frame-rate player kinematics: horizontal steering with screen wrap, gravity,
// platform bounce and floor loss detection. All state advances on frame_tick while Run is high.
module player_motion #(
    parameter int X_START  = 320,
    parameter int Y_START  = 400,
    parameter int GRAVITY  = 1,
    parameter int JUMP_VEL = 12,
    parameter int MAX_FALL = 12,
    parameter int X_STEP   = 3,
    parameter int X_MAX    = 639,
    parameter int Y_TOP    = 32,
    parameter int Y_FLOOR  = 479
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Run,
    input  logic              frame_tick,
    input  logic              key_left,
    input  logic              key_right,
    input  logic              platform_hit,
    output logic [9:0]        PlayerX,
    output logic [9:0]        PlayerY,
    output logic signed [7:0] VelY,
    output logic              Bounce,
    output logic              Fell
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RISING  = 2'd1;
    localparam logic [1:0] FALLING = 2'd2;
    localparam logic [1:0] DEAD    = 2'd3;

    localparam logic [9:0]         X_START_U  = 10'(X_START);
    localparam logic [9:0]         Y_START_U  = 10'(Y_START);
    localparam logic [9:0]         X_STEP_U   = 10'(X_STEP);
    localparam logic [9:0]         X_MAX_U    = 10'(X_MAX);
    localparam logic [9:0]         X_WIDTH_U  = 10'(X_MAX + 1);
    localparam logic [9:0]         Y_TOP_U    = 10'(Y_TOP);
    localparam logic [9:0]         Y_FLOOR_U  = 10'(Y_FLOOR);
    localparam logic signed [10:0] Y_TOP_S    = 11'(Y_TOP);
    localparam logic signed [10:0] Y_FLOOR_S  = 11'(Y_FLOOR);
    localparam logic signed [8:0]  GRAVITY_S  = 9'(GRAVITY);
    localparam logic signed [8:0]  MAX_FALL_S = 9'(MAX_FALL);
    localparam logic signed [7:0]  MAX_FALL_B = 8'(MAX_FALL);
    localparam logic signed [7:0]  LAUNCH_VEL = 8'(-JUMP_VEL);

    logic [1:0]        state_reg, state_next;
    logic [9:0]        x_reg, x_next;
    logic [9:0]        y_reg, y_next;
    logic signed [7:0] vel_reg, vel_next;
    logic              bounce_reg, bounce_next;
    logic              fell_reg, fell_next;

    logic              update;
    logic signed [10:0] y_sum;
    logic signed [8:0] vel_inc;
    logic signed [7:0] vel_sat;
    logic [9:0]        x_left, x_right, x_move;

    assign update = frame_tick & Run;

    // Position sum uses the pre-update velocity; gravity is applied afterwards.
    assign y_sum   = $signed({1'b0, y_reg}) + $signed({{3{vel_reg[7]}}, vel_reg});
    assign vel_inc = $signed({vel_reg[7], vel_reg}) + GRAVITY_S;
    assign vel_sat = (vel_inc > MAX_FALL_S) ? MAX_FALL_B : vel_inc[7:0];

    // Wrap arithmetic stays inside 10 bits: worst case is X_MAX + X_STEP.
    assign x_left  = (x_reg < X_STEP_U) ? (x_reg + X_WIDTH_U - X_STEP_U) : (x_reg - X_STEP_U);
    assign x_right = ((x_reg + X_STEP_U) > X_MAX_U) ? (x_reg + X_STEP_U - X_WIDTH_U)
                                                    : (x_reg + X_STEP_U);

    always_comb begin
        x_move = x_reg;
        case ({key_left, key_right})
            2'b10:   x_move = x_left;
            2'b01:   x_move = x_right;
            default: x_move = x_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        vel_next    = vel_reg;
        bounce_next = 1'b0;
        fell_next   = fell_reg;
        case (state_reg)
            IDLE: begin
                if (update) begin
                    vel_next   = LAUNCH_VEL;
                    state_next = RISING;
                end
            end
            RISING, FALLING: begin
                if (update) begin
                    x_next = x_move;
                    // A bounce takes priority over the floor: the foot landed first.
                    if (state_reg == FALLING && platform_hit) begin
                        vel_next    = LAUNCH_VEL;
                        bounce_next = 1'b1;
                        state_next  = RISING;
                    end else if (y_sum >= Y_FLOOR_S) begin
                        y_next     = Y_FLOOR_U;
                        vel_next   = 8'sd0;
                        fell_next  = 1'b1;
                        state_next = DEAD;
                    end else begin
                        y_next     = (y_sum < Y_TOP_S) ? Y_TOP_U : y_sum[9:0];
                        vel_next   = vel_sat;
                        state_next = vel_sat[7] ? RISING : FALLING;
                    end
                end
            end
            default: begin
                fell_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg  <= IDLE;
            x_reg      <= X_START_U;
            y_reg      <= Y_START_U;
            vel_reg    <= 8'sd0;
            bounce_reg <= 1'b0;
            fell_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            vel_reg    <= vel_next;
            bounce_reg <= bounce_next;
            fell_reg   <= fell_next;
        end
    end

    assign PlayerX = x_reg;
    assign PlayerY = y_reg;
    assign VelY    = vel_reg;
    assign Bounce  = bounce_reg;
    assign Fell    = fell_reg;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: a per-cycle vector table for the opening jump
// and bounce, then hand sequences for pause, reset priority, wrap and floor loss.
module tb_player_motion;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Run;
    logic              frame_tick;
    logic              key_left;
    logic              key_right;
    logic              platform_hit;
    logic [9:0]        PlayerX;
    logic [9:0]        PlayerY;
    logic signed [7:0] VelY;
    logic              Bounce;
    logic              Fell;

    int n_checks = 0;
    int n_fail   = 0;

    player_motion dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .frame_tick   (frame_tick),
        .key_left     (key_left),
        .key_right    (key_right),
        .platform_hit (platform_hit),
        .PlayerX      (PlayerX),
        .PlayerY      (PlayerY),
        .VelY         (VelY),
        .Bounce       (Bounce),
        .Fell         (Fell)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic run;
        logic tick;
        logic left;
        logic right;
        logic hit;
        int   ex;
        int   ey;
        int   ev;
        logic eb;
        logic ef;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input int ex, input int ey, input int ev,
                         input logic eb, input logic ef);
        n_checks++;
        if (int'(PlayerX) != ex || int'(PlayerY) != ey || int'(VelY) != ev ||
            Bounce !== eb || Fell !== ef) begin
            n_fail++;
            $display("FAIL %s: got X=%0d Y=%0d V=%0d B=%b F=%b, expected X=%0d Y=%0d V=%0d B=%b F=%b",
                     name, PlayerX, PlayerY, VelY, Bounce, Fell, ex, ey, ev, eb, ef);
        end else begin
            $display("ok   %s: X=%0d Y=%0d V=%0d B=%b F=%b",
                     name, PlayerX, PlayerY, VelY, Bounce, Fell);
        end
    endtask

    task automatic step(input logic run, input logic tick, input logic l, input logic r,
                        input logic h);
        Run = run; frame_tick = tick; key_left = l; key_right = r; platform_hit = h;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        // run tick  L  R  hit   X    Y    V   B  F
        vecs[0]  = '{1, 1, 0, 0, 0, 320, 400, -12, 0, 0};  // IDLE launch
        vecs[1]  = '{1, 1, 0, 1, 1, 323, 388, -11, 0, 0};  // hit ignored while rising
        vecs[2]  = '{1, 0, 0, 0, 0, 323, 388, -11, 0, 0};  // no tick: hold
        vecs[3]  = '{0, 1, 1, 0, 0, 323, 388, -11, 0, 0};  // tick dropped when paused
        vecs[4]  = '{1, 1, 1, 0, 0, 320, 377, -10, 0, 0};
        vecs[5]  = '{1, 1, 1, 1, 0, 320, 367,  -9, 0, 0};  // both keys: hold X
        vecs[6]  = '{1, 1, 0, 0, 0, 320, 358,  -8, 0, 0};
        vecs[7]  = '{1, 1, 0, 0, 0, 320, 350,  -7, 0, 0};
        vecs[8]  = '{1, 1, 0, 0, 0, 320, 343,  -6, 0, 0};
        vecs[9]  = '{1, 1, 0, 0, 0, 320, 337,  -5, 0, 0};
        vecs[10] = '{1, 1, 0, 0, 0, 320, 332,  -4, 0, 0};
        vecs[11] = '{1, 1, 0, 0, 0, 320, 328,  -3, 0, 0};
        vecs[12] = '{1, 1, 0, 0, 0, 320, 325,  -2, 0, 0};
        vecs[13] = '{1, 1, 0, 0, 0, 320, 323,  -1, 0, 0};
        vecs[14] = '{1, 1, 0, 0, 0, 320, 322,   0, 0, 0};  // apex, now falling
        vecs[15] = '{1, 1, 0, 0, 0, 320, 322,   1, 0, 0};
        vecs[16] = '{1, 1, 0, 0, 0, 320, 323,   2, 0, 0};
        vecs[17] = '{1, 1, 0, 0, 0, 320, 325,   3, 0, 0};
        vecs[18] = '{1, 1, 0, 0, 0, 320, 328,   4, 0, 0};
        vecs[19] = '{1, 1, 0, 0, 0, 320, 332,   5, 0, 0};
        vecs[20] = '{1, 1, 0, 0, 1, 320, 332, -12, 1, 0};  // bounce
        vecs[21] = '{1, 0, 0, 0, 0, 320, 332, -12, 0, 0};  // pulse is one cycle
        vecs[22] = '{1, 1, 0, 0, 1, 320, 320, -11, 0, 0};  // rising again, hit ignored

        Reset = 1'b1; Run = 1'b0; frame_tick = 1'b0;
        key_left = 1'b0; key_right = 1'b0; platform_hit = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset", 320, 400, 0, 1'b0, 1'b0);
        Reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].run, vecs[i].tick, vecs[i].left, vecs[i].right, vecs[i].hit);
            check($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ev,
                  vecs[i].eb, vecs[i].ef);
        end

        // Reset coinciding with an update tick mid-jump wins outright.
        Reset = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        Reset = 1'b0;
        check("reset_with_tick", 320, 400, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        check("relaunch", 320, 400, -12, 1'b0, 1'b0);

        // Pause across five ticks, then resume from the same values.
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("paused%0d", i), 320, 400, -12, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("resume", 320, 400 - 12, -11, 1'b0, 1'b0);

        // Horizontal wrap, kept alive by continuous platform contact.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 106; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (PlayerX != 10'd638) begin
            n_fail++;
            $display("FAIL walk_right: got X=%0d expected X=638", PlayerX);
        end
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (PlayerX != 10'd1) begin
            n_fail++;
            $display("FAIL wrap_right: got X=%0d expected X=1", PlayerX);
        end else $display("ok   wrap_right: X=%0d", PlayerX);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (PlayerX != 10'd638) begin
            n_fail++;
            $display("FAIL wrap_left: got X=%0d expected X=638", PlayerX);
        end else $display("ok   wrap_left: X=%0d", PlayerX);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (PlayerX != 10'd638) begin
            n_fail++;
            $display("FAIL both_keys: got X=%0d expected X=638", PlayerX);
        end else $display("ok   both_keys: X=%0d", PlayerX);

        // Free fall to the floor, bounded.
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200 && !Fell; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("floor", 320, 479, 0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("dead_tick", 320, 479, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("dead_run_low", 320, 479, 0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("dead_run_high", 320, 479, 0, 1'b0, 1'b1);
        do_reset();
        check("reset_after_dead", 320, 400, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, expected completion");
        $fatal(1);
    end

endmodule
